u_report: RTL and testbench

Frame serializer on the transmit side of the host link. It snapshots the interpolation command field set (shape, method, start/end points, direction, speed, acceleration) and emits it as a 13-byte frame, one byte at a time, to the UART transmitter. The byte layout is identical to the one the host-side receive path unpacks, so a transmit-to-receive loopback reproduces every field bit-exact. It sits between the interpolation control logic (field source) and the UART TX core (byte sink).

---
 rtl/u_report.sv | 152 +++++++++++++++
 tb/tb_u_report.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_report.sv
`default_nettype none
// ============================================================================
// Module : u_report
// Brief  : Snapshots the interpolation command fields and serializes them as
//          a 13-byte frame, one byte per UART TX handshake.
// Rev    : 1.0
// ============================================================================
module u_report #(
  parameter int TOTAL_BYTES = 13
) (
  input  logic        sys_clk,
  input  logic        sys_rst_h,
  input  logic        send_reqH,
  input  logic        shape,
  input  logic [1:0]  method,
  input  logic [15:0] Xs,
  input  logic [15:0] Ys,
  input  logic [15:0] Xe,
  input  logic [15:0] Ye,
  input  logic        direct,
  input  logic [7:0]  max_speed,
  input  logic [7:0]  accelerate,
  input  logic        tx_busyH,
  output logic [7:0]  tx_dataH,
  output logic        tx_startH,
  output logic        busyH,
  output logic        send_doneH
);

  localparam int            IW       = $clog2(TOTAL_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    snap_q [TOTAL_BYTES];
  logic [7:0]    snap_d [TOTAL_BYTES];
  logic [7:0]    frame  [TOTAL_BYTES];
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Wire layout shared with the host-side unpacker; words go low byte first.
  always_comb begin
    for (int i = 0; i < TOTAL_BYTES; i++) begin
      frame[i] = 8'h00;
    end
    frame[0]  = {7'b0, shape};
    frame[1]  = {6'b0, method};
    frame[2]  = Xs[7:0];
    frame[3]  = Xs[15:8];
    frame[4]  = Ys[7:0];
    frame[5]  = Ys[15:8];
    frame[6]  = Xe[7:0];
    frame[7]  = Xe[15:8];
    frame[8]  = Ye[7:0];
    frame[9]  = Ye[15:8];
    frame[10] = {7'b0, direct};
    frame[11] = max_speed;
    frame[12] = accelerate;
  end

  always_ff @(posedge sys_clk or posedge sys_rst_h) begin
    if (sys_rst_h) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < TOTAL_BYTES; i++) begin
        snap_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int i = 0; i < TOTAL_BYTES; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    for (int i = 0; i < TOTAL_BYTES; i++) begin
      snap_d[i] = snap_q[i];
    end

    unique case (state_q)
      S_IDLE: begin
        if (send_reqH) begin
          for (int i = 0; i < TOTAL_BYTES; i++) begin
            snap_d[i] = frame[i];
          end
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SEND;
        end
      end
      // Hold off while the transmitter is still busy with someone else's byte.
      S_SEND: begin
        if (!tx_busyH) begin
          tx_data_d  = snap_q[idx_q];
          tx_start_d = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busyH) begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busyH) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_dataH   = tx_data_q;
  assign tx_startH  = tx_start_q;
  assign busyH      = busy_q;
  assign send_doneH = done_q;

endmodule
`default_nettype wire

// File: tb/tb_u_report.sv
`default_nettype none
// ============================================================================
// Module : tb_u_report
// Brief  : Self-checking bench for u_report: vector table, hand-written corner
//          sequences and randomized loopback against a field-level model.
// Rev    : 1.0
// ============================================================================
module tb_u_report;

  typedef struct packed {
    logic        shape;
    logic [1:0]  method;
    logic [15:0] xs;
    logic [15:0] ys;
    logic [15:0] xe;
    logic [15:0] ye;
    logic        direct;
    logic [7:0]  spd;
    logic [7:0]  acc;
  } fields_t;

  typedef struct packed {
    fields_t          f;
    logic [12:0][7:0] exp;
  } vec_t;

  logic        sys_clk;
  logic        sys_rst_h;
  logic        send_reqH;
  logic        shape;
  logic [1:0]  method;
  logic [15:0] Xs, Ys, Xe, Ye;
  logic        direct;
  logic [7:0]  max_speed, accelerate;
  logic        tx_busyH;
  logic [7:0]  tx_dataH;
  logic        tx_startH;
  logic        busyH;
  logic        send_doneH;

  int n_cmp  = 0;
  int n_fail = 0;

  // transmitter model state
  int          tx_lat = 1;
  int          tx_dur = 10;
  int          ph = 0, lat_c = 0, dur_c = 0;
  logic        tx_busy_m = 1'b0;
  logic        hold_busy = 1'b0;
  logic        prev_start = 1'b0, prev_done = 1'b0;
  int          starts = 0;
  int          done_cnt = 0;
  logic [7:0]  rxq[$];

  assign tx_busyH = tx_busy_m | hold_busy;

  u_report #(.TOTAL_BYTES(13)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_h  (sys_rst_h),
    .send_reqH  (send_reqH),
    .shape      (shape),
    .method     (method),
    .Xs         (Xs),
    .Ys         (Ys),
    .Xe         (Xe),
    .Ye         (Ye),
    .direct     (direct),
    .max_speed  (max_speed),
    .accelerate (accelerate),
    .tx_busyH   (tx_busyH),
    .tx_dataH   (tx_dataH),
    .tx_startH  (tx_startH),
    .busyH      (busyH),
    .send_doneH (send_doneH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Byte sink: captures strobed bytes and plays busy with configurable latency/length.
  always @(negedge sys_clk) begin
    if (sys_rst_h) begin
      ph = 0;
      tx_busy_m = 1'b0;
      prev_start = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (tx_startH) begin
        check("start_not_back_to_back", 32'(prev_start), 0);
        rxq.push_back(tx_dataH);
        starts++;
      end
      if (send_doneH) begin
        done_cnt++;
        check("done_single_cycle", 32'(prev_done), 0);
      end
      prev_start = tx_startH;
      prev_done  = send_doneH;
      case (ph)
        0: if (tx_startH) begin lat_c = tx_lat; ph = 1; end
        1: begin
          lat_c--;
          if (lat_c == 0) begin tx_busy_m = 1'b1; dur_c = tx_dur; ph = 2; end
        end
        default: begin
          dur_c--;
          if (dur_c == 0) begin tx_busy_m = 1'b0; ph = 0; end
        end
      endcase
    end
  end

  function automatic fields_t mk(logic s, logic [1:0] m, logic [15:0] xs, logic [15:0] ys,
                                 logic [15:0] xe, logic [15:0] ye, logic d,
                                 logic [7:0] sp, logic [7:0] ac);
    fields_t f;
    f.shape = s; f.method = m; f.xs = xs; f.ys = ys; f.xe = xe; f.ye = ye;
    f.direct = d; f.spd = sp; f.acc = ac;
    return f;
  endfunction

  function automatic fields_t rand_fields();
    return mk(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
  endfunction

  // Reference: frame bytes from field values by plain arithmetic.
  function automatic logic [12:0][7:0] model_frame(fields_t f);
    int b [13];
    logic [12:0][7:0] r;
    b[0]  = f.shape ? 1 : 0;
    b[1]  = int'(f.method);
    b[2]  = int'(f.xs) % 256;  b[3] = int'(f.xs) / 256;
    b[4]  = int'(f.ys) % 256;  b[5] = int'(f.ys) / 256;
    b[6]  = int'(f.xe) % 256;  b[7] = int'(f.xe) / 256;
    b[8]  = int'(f.ye) % 256;  b[9] = int'(f.ye) / 256;
    b[10] = f.direct ? 1 : 0;
    b[11] = int'(f.spd);
    b[12] = int'(f.acc);
    for (int i = 0; i < 13; i++) r[i] = 8'(b[i]);
    return r;
  endfunction

  task automatic apply_fields(input fields_t f);
    shape = f.shape; method = f.method; Xs = f.xs; Ys = f.ys; Xe = f.xe; Ye = f.ye;
    direct = f.direct; max_speed = f.spd; accelerate = f.acc;
  endtask

  task automatic wait_done(input string nm, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge sys_clk);
      if (send_doneH) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: send_doneH not seen within 5000 cycles", nm);
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000 && !ok; c++) begin
      @(negedge sys_clk);
      if (rxq.size() >= n) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_bytes: got %0d bytes, expected %0d", rxq.size(), n);
    end
  endtask

  task automatic send_frame(input string nm, input bit scramble, input bit chk_t, output bit ok);
    rxq.delete();
    done_cnt = 0;
    send_reqH = 1'b1;
    @(negedge sys_clk);
    send_reqH = 1'b0;
    if (scramble) apply_fields(rand_fields());
    if (chk_t) begin
      check({nm, "_busy_after_accept"}, 32'(busyH), 1);
      check({nm, "_no_start_at_E0"}, 32'(tx_startH), 0);
      @(negedge sys_clk);
      check({nm, "_start_at_E0p1"}, 32'(tx_startH), 1);
    end
    wait_done(nm, ok);
    if (ok) begin
      check({nm, "_busy_low_with_done"}, 32'(busyH), 0);
      @(negedge sys_clk);
      check({nm, "_done_count"}, 32'(done_cnt), 1);
    end
  endtask

  task automatic compare_frame(input string nm, input logic [12:0][7:0] exp);
    check({nm, "_len"}, 32'(rxq.size()), 13);
    for (int i = 0; i < 13 && i < rxq.size(); i++)
      check($sformatf("%s_b%0d", nm, i), 32'(rxq[i]), 32'(exp[i]));
  endtask

  vec_t    vecs [3];
  fields_t f0, f1;
  bit      ok;

  initial begin
    vecs[0].f   = mk(1'b1, 2'd2, 16'h1234, 16'hFFFE, 16'h0080, 16'h7F01, 1'b1, 8'hC8, 8'h05);
    vecs[0].exp = {8'h05, 8'hC8, 8'h01, 8'h7F, 8'h01, 8'h00, 8'h80, 8'hFF,
                   8'hFE, 8'h12, 8'h34, 8'h02, 8'h01};
    vecs[1].f   = mk(1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 8'h00, 8'h00);
    vecs[1].exp = '0;
    vecs[2].f   = mk(1'b1, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 8'hFF, 8'hFF);
    vecs[2].exp = {8'hFF, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                   8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h01};

    sys_rst_h = 1'b1;
    send_reqH = 1'b0;
    apply_fields(vecs[1].f);
    repeat (3) @(negedge sys_clk);
    check("rst_tx_data", 32'(tx_dataH), 0);
    check("rst_tx_start", 32'(tx_startH), 0);
    check("rst_busy", 32'(busyH), 0);
    check("rst_done", 32'(send_doneH), 0);
    sys_rst_h = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Vector table: content, order, acceptance timing
    for (int v = 0; v < 3; v++) begin
      apply_fields(vecs[v].f);
      tx_lat = 1; tx_dur = 10;
      send_frame($sformatf("vec%0d", v), 1'b0, v == 0, ok);
      compare_frame($sformatf("vec%0d", v), vecs[v].exp);
      repeat (2) @(negedge sys_clk);
    end

    // Snapshot stability: fields scrambled right after acceptance
    f0 = rand_fields();
    apply_fields(f0);
    tx_lat = 2; tx_dur = 3;
    send_frame("snap", 1'b1, 1'b1, ok);
    compare_frame("snap", model_frame(f0));
    repeat (2) @(negedge sys_clk);

    // Request pulse while busy at byte 5 is dropped
    f0 = rand_fields();
    apply_fields(f0);
    tx_lat = 1; tx_dur = 4;
    rxq.delete(); done_cnt = 0; starts = 0;
    send_reqH = 1'b1; @(negedge sys_clk); send_reqH = 1'b0;
    wait_bytes(6, ok);
    send_reqH = 1'b1; @(negedge sys_clk); send_reqH = 1'b0;
    wait_done("req_busy", ok);
    repeat (40) @(negedge sys_clk);
    check("req_busy_starts", 32'(starts), 13);
    check("req_busy_dones", 32'(done_cnt), 1);
    check("req_busy_idle", 32'(busyH), 0);
    compare_frame("req_busy", model_frame(f0));

    // Held request: second frame starts on the edge ending the done cycle
    rxq.delete(); done_cnt = 0;
    send_reqH = 1'b1;
    wait_done("held_first", ok);
    check("held_busy_low_on_done", 32'(busyH), 0);
    @(negedge sys_clk);
    check("held_busy_restart", 32'(busyH), 1);
    send_reqH = 1'b0;
    wait_done("held_second", ok);
    @(negedge sys_clk);
    check("held_bytes", 32'(rxq.size()), 26);
    check("held_dones", 32'(done_cnt), 2);
    repeat (2) @(negedge sys_clk);

    // Transmitter held busy for 50 cycles at acceptance
    f0 = rand_fields();
    apply_fields(f0);
    rxq.delete(); done_cnt = 0; starts = 0;
    hold_busy = 1'b1;
    send_reqH = 1'b1; @(negedge sys_clk); send_reqH = 1'b0;
    repeat (49) @(negedge sys_clk);
    check("hold_no_start", 32'(starts), 0);
    check("hold_busyH", 32'(busyH), 1);
    hold_busy = 1'b0;
    @(negedge sys_clk);
    check("hold_release_start", 32'(tx_startH), 1);
    check("hold_release_byte0", 32'(tx_dataH), 32'(model_frame(f0)[0]));
    wait_done("hold", ok);
    @(negedge sys_clk);
    compare_frame("hold", model_frame(f0));

    // Asynchronous reset during byte 7, then a fresh frame
    f0 = rand_fields();
    apply_fields(f0);
    tx_lat = 1; tx_dur = 6;
    rxq.delete(); done_cnt = 0;
    send_reqH = 1'b1; @(negedge sys_clk); send_reqH = 1'b0;
    wait_bytes(8, ok);
    #2 sys_rst_h = 1'b1;
    #1;
    check("arst_tx_data", 32'(tx_dataH), 0);
    check("arst_tx_start", 32'(tx_startH), 0);
    check("arst_busy", 32'(busyH), 0);
    check("arst_done", 32'(send_doneH), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_h = 1'b0;
    check("arst_no_done", 32'(done_cnt), 0);
    @(negedge sys_clk);
    f1 = mk(~f0.shape, ~f0.method, ~f0.xs, ~f0.ys, ~f0.xe, ~f0.ye, ~f0.direct, ~f0.spd, ~f0.acc);
    apply_fields(f1);
    send_frame("after_rst", 1'b0, 1'b1, ok);
    compare_frame("after_rst", model_frame(f1));

    // Randomized loopback: unpack received bytes back into fields
    for (int n = 0; n < 20; n++) begin
      f0 = rand_fields();
      apply_fields(f0);
      tx_lat = int'($urandom_range(1, 3));
      tx_dur = int'($urandom_range(1, 12));
      send_frame($sformatf("lb%0d", n), 1'b1, 1'b0, ok);
      check($sformatf("lb%0d_len", n), 32'(rxq.size()), 13);
      if (rxq.size() == 13) begin
        check($sformatf("lb%0d_shape", n), 32'(rxq[0]), 32'(f0.shape));
        check($sformatf("lb%0d_method", n), 32'(rxq[1]), 32'(f0.method));
        check($sformatf("lb%0d_xs", n), 32'(rxq[2]) + 256 * 32'(rxq[3]), 32'(f0.xs));
        check($sformatf("lb%0d_ys", n), 32'(rxq[4]) + 256 * 32'(rxq[5]), 32'(f0.ys));
        check($sformatf("lb%0d_xe", n), 32'(rxq[6]) + 256 * 32'(rxq[7]), 32'(f0.xe));
        check($sformatf("lb%0d_ye", n), 32'(rxq[8]) + 256 * 32'(rxq[9]), 32'(f0.ye));
        check($sformatf("lb%0d_direct", n), 32'(rxq[10]), 32'(f0.direct));
        check($sformatf("lb%0d_speed", n), 32'(rxq[11]), 32'(f0.spd));
        check($sformatf("lb%0d_accel", n), 32'(rxq[12]), 32'(f0.acc));
      end
      @(negedge sys_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
